// File: rtl/fft_pkg.sv
// Shared constants, transmit-state encoding and the bit-reverse helper for the
// FFT datapath. The control state machine's transmit path imports the same
// bitrev() so that both sides agree on the output ordering.
package fft_pkg;

  localparam int N_POINTS = 16;  // samples per frame (power of 2)
  localparam int ADDR_W   = 4;   // log2(N_POINTS)
  localparam int DATA_W   = 32;  // {real, imag}, each DATA_W/2 bits

  typedef enum logic [2:0] {
    TX_IDLE  = 3'b001,
    TX_ISSUE = 3'b010,
    TX_DRAIN = 3'b100
  } tx_state_t;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] r;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      r[i] = addr[ADDR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_tx_scheduler_if.sv
// Bundle of the sample-RAM read port and the output sample stream.
//   rd_en_F/rd_addr_F  read strobe/address (data returns on rd_data next cycle)
//   out_push_F/out_real_F/out_imag_F  output sample, out_stall consumer hold
// master: the scheduler. slave: the RAM / consumer side.
interface fft_tx_scheduler_if;
  import fft_pkg::*;

  logic                  rd_en_F;
  logic [ADDR_W-1:0]     rd_addr_F;
  logic [DATA_W-1:0]     rd_data;
  logic                  out_push_F;
  logic [DATA_W/2-1:0]   out_real_F;
  logic [DATA_W/2-1:0]   out_imag_F;
  logic                  out_stall;

  modport master (
    output rd_en_F, rd_addr_F, out_push_F, out_real_F, out_imag_F,
    input  rd_data, out_stall
  );

  modport slave (
    input  rd_en_F, rd_addr_F, out_push_F, out_real_F, out_imag_F,
    output rd_data, out_stall
  );
endinterface

// File: rtl/fft_skid_buf.sv
// Two-entry FIFO with bypass: when empty, a word presented on din can be
// popped in the same cycle it arrives.
//   clk, reset  clock / synchronous active-high reset
//   push, din   write strobe and data
//   pop, dout   read strobe and head data (din when empty)
//   count       current occupancy 0..2
//   empty, full occupancy flags
module fft_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         wr;
  logic         rd;

  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);
  assign dout  = empty ? din : mem[rd_ptr];

  // A word popped straight through the bypass never touches storage.
  assign wr = push && !(empty && pop);
  assign rd = pop && !empty;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= ~wr_ptr;
      if (rd) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, wr} - {1'b0, rd};
    end
  end

endmodule

// File: rtl/fft_tx_scheduler.sv
// Drains a finished 16-point FFT frame from sample RAM read port 1 to the
// output stream in bit-reversed address order. Reads are credit-limited so
// the 2-entry skid buffer absorbs any out_stall pattern without loss.
//   clk, reset    clock / synchronous active-high reset
//   frame_ready   1-cycle pulse: frame in RAM is final
//   busy_F        frame drain in progress, RAM read port owned
//   frame_done_F  pulse with the push of the last sample
//   overrun_F     sticky: frame_ready seen while busy_F=1
//   bus           RAM read port + output sample stream (master side)
module fft_tx_scheduler
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_ready,
  output logic                busy_F,
  output logic                frame_done_F,
  output logic                overrun_F,
  fft_tx_scheduler_if.master  bus
);

  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(N_POINTS - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  tx_state_t           state, state_nxt;
  logic [ADDR_W:0]     rd_cnt, tx_cnt;
  logic                rd_en_q, rd_vld;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                push_q, done_q, overrun_q;
  logic [DATA_W/2-1:0] real_q, imag_q;
  logic [DATA_W-1:0]   buf_dout;
  logic [1:0]          buf_count;
  logic                buf_empty, buf_full;
  logic                pop, last_pop, issue;
  logic [2:0]          load;

  fft_skid_buf #(.W(DATA_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (rd_vld),
    .pop   (pop),
    .din   (bus.rd_data),
    .dout  (buf_dout),
    .count (buf_count),
    .empty (buf_empty),
    .full  (buf_full)
  );

  assign pop      = (!buf_empty || rd_vld) && !bus.out_stall;
  assign last_pop = pop && (tx_cnt == CNT_LAST);

  // Words held plus words still on their way from the RAM, after this
  // cycle's pop, must leave room for one more if the stall never releases.
  assign load = {1'b0, buf_count} + {2'b0, rd_vld} + {2'b0, rd_en_q} - {2'b0, pop};

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      TX_IDLE: begin
        issue = frame_ready;  // first read leaves in the acceptance cycle
        if (frame_ready) state_nxt = TX_ISSUE;
      end
      TX_ISSUE: begin
        issue = (load <= 3'd1);
        if (issue && rd_cnt == CNT_LAST) state_nxt = TX_DRAIN;
      end
      TX_DRAIN: begin
        if (done_q) state_nxt = TX_IDLE;
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= TX_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt    <= '0;
      tx_cnt    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_vld    <= 1'b0;
      push_q    <= 1'b0;
      real_q    <= '0;
      imag_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rd_en_q <= issue;
      rd_vld  <= rd_en_q;
      if (issue) begin
        rd_addr_q <= bitrev(rd_cnt[ADDR_W-1:0]);
        rd_cnt    <= rd_cnt + CNT_ONE;
      end else if (done_q) begin
        rd_cnt <= '0;
      end
      push_q <= pop;
      done_q <= last_pop;
      if (pop) begin
        {real_q, imag_q} <= buf_dout;
        tx_cnt           <= last_pop ? '0 : tx_cnt + CNT_ONE;
      end
      overrun_q <= overrun_q || (frame_ready && busy_F);
    end
  end

  // The read credit keeps the skid buffer from ever taking a third word.
  assert property (@(posedge clk) disable iff (reset) !(buf_full && rd_vld && !pop));

  assign busy_F         = (state != TX_IDLE);
  assign frame_done_F   = done_q;
  assign overrun_F      = overrun_q;
  assign bus.rd_en_F    = rd_en_q;
  assign bus.rd_addr_F  = rd_addr_q;
  assign bus.out_push_F = push_q;
  assign bus.out_real_F = real_q;
  assign bus.out_imag_F = imag_q;

endmodule

// File: tb/tb_fft_tx_scheduler.sv
module tb_fft_tx_scheduler;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic frame_ready;
  logic busy_F, frame_done_F, overrun_F;

  fft_tx_scheduler_if bus();

  fft_tx_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .frame_ready  (frame_ready),
    .busy_F       (busy_F),
    .frame_done_F (frame_done_F),
    .overrun_F    (overrun_F),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Sample RAM: data valid the cycle after the read strobe.
  logic [31:0] ram [16];
  always @(posedge clk) if (bus.rd_en_F) bus.rd_data <= ram[bus.rd_addr_F];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int t0 = 0;

  int          rd_cyc_q[$];
  int          rd_addr_q[$];
  int          push_cyc_q[$];
  logic [31:0] push_q[$];
  int          done_q[$];
  logic        busy_log[1024];
  logic        ovr_log[1024];
  logic        stall_log[1024];

  always @(negedge clk) begin : mon
    int rel;
    rel = cyc - t0;
    if (bus.rd_en_F) begin
      rd_cyc_q.push_back(rel);
      rd_addr_q.push_back(int'(bus.rd_addr_F));
    end
    if (bus.out_push_F) begin
      push_cyc_q.push_back(rel);
      push_q.push_back({bus.out_real_F, bus.out_imag_F});
    end
    if (frame_done_F) done_q.push_back(rel);
    if (rel >= 0 && rel < 1024) begin
      busy_log[rel]  = busy_F;
      ovr_log[rel]   = overrun_F;
      stall_log[rel] = bus.out_stall;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int brev(input int i);
    int r = 0;
    for (int b = 0; b < 4; b++) if (((i >> b) & 1) == 1) r |= (1 << (3 - b));
    return r;
  endfunction

  // Output stream must equal the RAM read in bit-reversed order.
  function automatic int data_errs(input int base);
    int errs = 0;
    for (int i = 0; i < 16; i++) begin
      if (base + i >= push_q.size()) errs++;
      else if (push_q[base + i] !== ram[brev(i)]) errs++;
    end
    return errs;
  endfunction

  // A push in cycle p requires out_stall low in cycle p-1.
  function automatic int gate_errs();
    int errs = 0;
    foreach (push_cyc_q[i]) begin
      if (push_cyc_q[i] >= 1 && push_cyc_q[i] < 1024 && stall_log[push_cyc_q[i] - 1] === 1'b1)
        errs++;
    end
    return errs;
  endfunction

  function automatic logic stall_for(input int mode, input int c);
    case (mode)
      1:       return (c >= 2 && c <= 9);
      2:       return logic'($urandom % 2);
      default: return 1'b0;
    endcase
  endfunction

  task automatic fill_ram(input bit rnd);
    for (int k = 0; k < 16; k++)
      ram[k] = rnd ? $urandom : {16'(k), ~16'(k)};
  endtask

  task automatic clear_logs();
    rd_cyc_q.delete();
    rd_addr_q.delete();
    push_cyc_q.delete();
    push_q.delete();
    done_q.delete();
  endtask

  task automatic run_frame(input int mode, input int fr2_at, input int n_done, input int budget);
    int c;
    int settle;
    clear_logs();
    @(posedge clk); #1;
    t0 = cyc;
    frame_ready   = 1'b1;
    bus.out_stall = stall_for(mode, 0);
    c = 0;
    settle = -1;
    while (1) begin
      @(posedge clk); #1;
      c++;
      frame_ready   = (c == fr2_at);
      bus.out_stall = stall_for(mode, c);
      if (settle < 0 && done_q.size() >= n_done) settle = c + 6;
      if (c == settle) break;
      if (c >= budget) begin
        chk("frame_timeout_done_count", done_q.size(), n_done);
        break;
      end
    end
    frame_ready   = 1'b0;
    bus.out_stall = 1'b0;
  endtask

  task automatic check_idle_outputs(input string pfx);
    chk({pfx, "_busy"},     busy_F, 0);
    chk({pfx, "_rd_en"},    bus.rd_en_F, 0);
    chk({pfx, "_rd_addr"},  bus.rd_addr_F, 0);
    chk({pfx, "_push"},     bus.out_push_F, 0);
    chk({pfx, "_real"},     bus.out_real_F, 0);
    chk({pfx, "_imag"},     bus.out_imag_F, 0);
    chk({pfx, "_done"},     frame_done_F, 0);
    chk({pfx, "_overrun"},  overrun_F, 0);
  endtask

  initial begin
    int n;
    reset         = 1'b1;
    frame_ready   = 1'b0;
    bus.out_stall = 1'b0;
    fill_ram(0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst");

    // 1: stall-free frame, exact timing and order
    fill_ram(0);
    run_frame(0, -1, 1, 200);
    chk("t1_nreads", rd_addr_q.size(), 16);
    for (int i = 0; i < 16 && i < rd_addr_q.size(); i++) begin
      chk($sformatf("t1_addr%0d", i), rd_addr_q[i], brev(i));
      chk($sformatf("t1_rdcyc%0d", i), rd_cyc_q[i], i + 1);
    end
    chk("t1_npush", push_q.size(), 16);
    for (int i = 0; i < 16 && i < push_q.size(); i++) begin
      chk($sformatf("t1_pushcyc%0d", i), push_cyc_q[i], i + 3);
      chk($sformatf("t1_word%0d", i), push_q[i], {16'(brev(i)), ~16'(brev(i))});
    end
    chk("t1_ndone", done_q.size(), 1);
    if (done_q.size() > 0) chk("t1_done_cyc", done_q[0], 18);
    chk("t1_busy0", busy_log[0], 0);
    chk("t1_busy1", busy_log[1], 1);
    chk("t1_busy18", busy_log[18], 1);
    chk("t1_busy19", busy_log[19], 0);
    chk("t1_overrun", overrun_F, 0);

    // 2: stall held in cycles 2..9
    run_frame(1, -1, 1, 300);
    chk("t2_nreads", rd_addr_q.size(), 16);
    n = 0;
    foreach (rd_cyc_q[i]) if (rd_cyc_q[i] >= 3 && rd_cyc_q[i] <= 10) n++;
    chk("t2_reads_during_stall", n, 0);
    chk("t2_npush", push_q.size(), 16);
    chk("t2_data_errs", data_errs(0), 0);
    n = 0;
    foreach (push_cyc_q[i]) if (push_cyc_q[i] != 11 + i) n++;
    chk("t2_push_gap_errs", n, 0);
    chk("t2_ndone", done_q.size(), 1);
    if (done_q.size() > 0) chk("t2_done_cyc", done_q[0], 26);

    // 3: random stall over 100 frames of random data
    for (int f = 0; f < 100; f++) begin
      fill_ram(1);
      run_frame(2, -1, 1, 400);
      chk($sformatf("t3_f%0d_npush", f), push_q.size(), 16);
      chk($sformatf("t3_f%0d_ndone", f), done_q.size(), 1);
      chk($sformatf("t3_f%0d_data_errs", f), data_errs(0), 0);
      chk($sformatf("t3_f%0d_stall_gate_errs", f), gate_errs(), 0);
      if (done_q.size() > 0 && push_cyc_q.size() > 0)
        chk($sformatf("t3_f%0d_done_with_last", f), done_q[0], push_cyc_q[push_cyc_q.size() - 1]);
    end

    // 4: second frame_ready while busy
    fill_ram(0);
    run_frame(0, 5, 1, 200);
    chk("t4_ovr5", ovr_log[5], 0);
    chk("t4_ovr6", ovr_log[6], 1);
    chk("t4_ovr_sticky", overrun_F, 1);
    chk("t4_nreads", rd_addr_q.size(), 16);
    chk("t4_npush", push_q.size(), 16);
    chk("t4_data_errs", data_errs(0), 0);
    if (done_q.size() > 0) chk("t4_done_cyc", done_q[0], 18);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t4_ovr_after_reset", overrun_F, 0);

    // 5: reset mid-frame at cycle 8
    fill_ram(0);
    clear_logs();
    @(posedge clk); #1;
    t0 = cyc;
    frame_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      frame_ready = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_reads_before_rst", rd_addr_q.size(), 8);
    check_idle_outputs("t5");
    run_frame(0, -1, 1, 200);
    chk("t5_nreads", rd_addr_q.size(), 16);
    if (rd_addr_q.size() > 0) begin
      chk("t5_first_addr", rd_addr_q[0], 0);
      chk("t5_first_rdcyc", rd_cyc_q[0], 1);
    end
    chk("t5_npush", push_q.size(), 16);
    chk("t5_data_errs", data_errs(0), 0);

    // 6: back-to-back frames
    fill_ram(0);
    run_frame(0, 19, 2, 300);
    chk("t6_nreads", rd_addr_q.size(), 32);
    if (rd_addr_q.size() > 16) begin
      chk("t6_f2_first_addr", rd_addr_q[16], 0);
      chk("t6_f2_first_rdcyc", rd_cyc_q[16], 20);
    end
    chk("t6_npush", push_q.size(), 32);
    chk("t6_f1_data_errs", data_errs(0), 0);
    chk("t6_f2_data_errs", data_errs(16), 0);
    chk("t6_ndone", done_q.size(), 2);
    if (done_q.size() > 1) begin
      chk("t6_done1", done_q[0], 18);
      chk("t6_done2", done_q[1], 37);
    end
    chk("t6_overrun", overrun_F, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
